// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the memory-access stage and its lane aligner.
// Holds opcode patterns, funct3 encodings, the access-size and LSU state enums,
// the latched memory-write payload, and small size/offset helpers.
package riscv_pkg;

    localparam int unsigned RV_XLEN = 32;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] I_ALL_LOADS  = 7'b0000011;
    localparam logic [6:0] S_ALL_STORES = 7'b0100011;
    localparam logic [6:0] R_ALL        = 7'b0110011;

    // Load/store funct3 encodings (instr[14:12])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // Write-side payload presented on the data-memory port
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_wr_t;

    // Access size from funct3; bit 2 only selects signedness
    function automatic lsu_size_t f3_to_size(input logic [2:0] f3);
        case (f3[1:0])
            F3_B[1:0]: f3_to_size = SZ_B;
            F3_H[1:0]: f3_to_size = SZ_H;
            default:   f3_to_size = SZ_W;
        endcase
    endfunction

    // Byte offset after forcing natural alignment for the access size
    function automatic logic [1:0] align_offset(input lsu_size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    align_offset = a;
            SZ_H:    align_offset = {a[1], 1'b0};
            default: align_offset = 2'b00;
        endcase
    endfunction

    // True when the raw offset is not naturally aligned for the access size
    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the memory-access stage.
//   size/offset     : access size and (already aligned) byte offset
//   is_unsigned     : zero-extend loads instead of sign-extending
//   store_data      : rs2 value to be placed on the write lanes
//   rdata           : raw read word from memory
//   be_c            : byte enables for the access
//   wdata_c         : store data replicated across lanes
//   load_data_c     : extracted and extended load result
module lsu_lane_align
    import riscv_pkg::*;
(
    input  lsu_size_t   size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] load_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_bit;

    // Lane select of the read word
    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Enables, write replication and load extension per size
    always_comb begin
        be_c        = 4'b0000;
        wdata_c     = 32'h0;
        load_data_c = 32'h0;
        sign_bit    = 1'b0;
        case (size)
            SZ_B: begin
                be_c        = 4'(4'b0001 << offset);
                wdata_c     = {4{store_data[7:0]}};
                sign_bit    = ~is_unsigned & byte_sel[7];
                load_data_c = {{24{sign_bit}}, byte_sel};
            end
            SZ_H: begin
                be_c        = 4'(4'b0011 << offset);
                wdata_c     = {2{store_data[15:0]}};
                sign_bit    = ~is_unsigned & half_sel[15];
                load_data_c = {{16{sign_bit}}, half_sel};
            end
            default: begin
                be_c        = 4'b1111;
                wdata_c     = store_data;
                load_data_c = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_lsu.sv
// Memory-access pipeline stage between execute and writeback (RV32I).
// Issues loads/stores over a req/gnt/rvalid port of variable latency, steers
// byte lanes, extends load data and stalls upstream while an access is open.
//   in_valid_i/in_ready_o       : execute-side handshake (ready only in IDLE)
//   instr_i/alu_result_i/store_data_i : instruction, address or ALU result, rs2
//   out_valid_o                 : one-cycle completion pulse
//   instr_o/alu_result_o/data_o : registered completed instruction and results
//   sel_rd_o                    : rd of instr_o for loads and R-type, else 0
//   fault_o                     : timeout (or misalignment trap) indication
//   mem_*                       : data-memory request/response port
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them down.
module mem_access_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned RVALID_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [XLEN-1:0]       instr_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic [XLEN-1:0]       store_data_i,
    output logic                  out_valid_o,
    output logic [XLEN-1:0]       instr_o,
    output logic [XLEN-1:0]       alu_result_o,
    output logic [XLEN-1:0]       data_o,
    output logic [4:0]            sel_rd_o,
    output logic                  fault_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i
);

    localparam int unsigned CNT_W  = (RVALID_TIMEOUT > 1) ? $clog2(RVALID_TIMEOUT) : 1;
    localparam bit          TO_EN  = (RVALID_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RVALID_TIMEOUT - 32'd1);

    if (XLEN != RV_XLEN) begin : g_bad_xlen
        $error("mem_access_lsu supports only XLEN = 32");
    end

    lsu_state_t      state_q, state_d;

    // Pending instruction context held while the memory access is open
    logic [31:0]     pend_instr_q, pend_instr_d;
    logic [31:0]     pend_alu_q,   pend_alu_d;
    lsu_size_t       size_q,       size_d;
    logic [1:0]      off_q,        off_d;
    logic            uns_q,        uns_d;
    logic            is_load_q,    is_load_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    // Next values of the registered outputs
    logic                  out_valid_d;
    logic [31:0]           instr_d, alu_d, data_d;
    logic                  fault_d;
    logic                  mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    lsu_wr_t               wr_q, wr_d;

    // Incoming instruction decode
    logic [6:0]  in_opc;
    logic        in_is_load, in_is_store, in_mem_op;
    lsu_size_t   in_size;
    logic [1:0]  in_off;
    logic        trap_c;
    logic        accept;

    // Lane aligner: issue side in IDLE, response side otherwise
    lsu_size_t   la_size;
    logic [1:0]  la_off;
    logic [3:0]  la_be;
    logic [31:0] la_wdata, la_load;

    assign in_opc      = instr_i[6:0];
    assign in_is_load  = (in_opc == I_ALL_LOADS);
    assign in_is_store = (in_opc == S_ALL_STORES);
    assign in_mem_op   = in_is_load | in_is_store;
    assign in_size     = f3_to_size(instr_i[14:12]);
    assign in_off      = align_offset(in_size, alu_result_i[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_c = in_mem_op & is_misaligned(in_size, alu_result_i[1:0]);
`else
    assign trap_c = 1'b0;
`endif

    assign in_ready_o = (state_q == IDLE);
    assign accept     = in_valid_i & in_ready_o;

    assign la_size = (state_q == IDLE) ? in_size : size_q;
    assign la_off  = (state_q == IDLE) ? in_off  : off_q;

    lsu_lane_align u_lane_align (
        .size        (la_size),
        .offset      (la_off),
        .is_unsigned (uns_q),
        .store_data  (store_data_i),
        .rdata       (mem_rdata_i),
        .be_c        (la_be),
        .wdata_c     (la_wdata),
        .load_data_c (la_load)
    );

    // rd is only architecturally written by loads and R-type here
    always_comb begin
        sel_rd_o = 5'd0;
        if ((instr_o[6:0] == I_ALL_LOADS) || (instr_o[6:0] == R_ALL)) begin
            sel_rd_o = instr_o[11:7];
        end
    end

    assign mem_we_o    = wr_q.we;
    assign mem_be_o    = wr_q.be;
    assign mem_wdata_o = wr_q.wdata;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        pend_instr_d = pend_instr_q;
        pend_alu_d   = pend_alu_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        is_load_d    = is_load_q;
        cnt_d        = cnt_q;
        out_valid_d  = 1'b0;
        fault_d      = 1'b0;
        instr_d      = instr_o;
        alu_d        = alu_result_o;
        data_d       = data_o;
        mem_req_d    = mem_req_o;
        mem_addr_d   = mem_addr_o;
        wr_d         = wr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_mem_op && !trap_c) begin
                        state_d      = REQ;
                        mem_req_d    = 1'b1;
                        mem_addr_d   = {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
                        wr_d.we      = in_is_store;
                        wr_d.be      = la_be;
                        wr_d.wdata   = in_is_store ? la_wdata : 32'h0;
                        pend_instr_d = instr_i;
                        pend_alu_d   = alu_result_i;
                        size_d       = in_size;
                        off_d        = in_off;
                        uns_d        = instr_i[14];
                        is_load_d    = in_is_load;
                        cnt_d        = '0;
                    end else begin
                        // Non-memory op or trapped access completes next cycle
                        out_valid_d = 1'b1;
                        fault_d     = trap_c;
                        instr_d     = instr_i;
                        alu_d       = alu_result_i;
                        data_d      = 32'h0;
                    end
                end
            end

            REQ: begin
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    wr_d.we   = 1'b0;
                    if (!is_load_q || mem_rvalid_i) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b1;
                        instr_d     = pend_instr_q;
                        alu_d       = pend_alu_q;
                        data_d      = is_load_q ? la_load : 32'h0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end

            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    instr_d     = pend_instr_q;
                    alu_d       = pend_alu_q;
                    data_d      = la_load;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    fault_d     = 1'b1;
                    instr_d     = pend_instr_q;
                    alu_d       = pend_alu_q;
                    data_d      = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_instr_q <= 32'h0;
            pend_alu_q   <= 32'h0;
            size_q       <= SZ_B;
            off_q        <= 2'b00;
            uns_q        <= 1'b0;
            is_load_q    <= 1'b0;
            cnt_q        <= '0;
            out_valid_o  <= 1'b0;
            fault_o      <= 1'b0;
            instr_o      <= 32'h0;
            alu_result_o <= 32'h0;
            data_o       <= 32'h0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            wr_q         <= '0;
        end else begin
            state_q      <= state_d;
            pend_instr_q <= pend_instr_d;
            pend_alu_q   <= pend_alu_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            is_load_q    <= is_load_d;
            cnt_q        <= cnt_d;
            out_valid_o  <= out_valid_d;
            fault_o      <= fault_d;
            instr_o      <= instr_d;
            alu_result_o <= alu_d;
            data_o       <= data_d;
            mem_req_o    <= mem_req_d;
            mem_addr_o   <= mem_addr_d;
            wr_q         <= wr_d;
        end
    end

endmodule
